// File: rtl/encoder_if.sv
// Request/result bundle for the priority encoder.
// The producer drives en/din; the encoder returns the registered dout/valid.
interface encoder_if #(
    parameter int WIDTH = 8
) ();
    localparam int OUT_W = $clog2(WIDTH);

    logic             en;
    logic [WIDTH-1:0] din;
    logic [OUT_W-1:0] dout;
    logic             valid;

    // Producer of requests, consumer of the encoded index
    modport master (
        output en,
        output din,
        input  dout,
        input  valid
    );

    // The encoder itself
    modport slave (
        input  en,
        input  din,
        output dout,
        output valid
    );
endinterface

// File: rtl/encoder.sv
// Registered WIDTH-to-$clog2(WIDTH) priority encoder with enable.
// The highest set bit of din wins. Bits below the winner never reach the
// outputs, so X/Z on them cannot propagate. One register stage, 1-cycle latency.
module encoder #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    encoder_if.slave   bus
);
    localparam int OUT_W = $clog2(WIDTH);

    // clear_chain[i] = 1 when every din bit at index >= i is 0.
    // clear_chain[WIDTH] is the empty prefix above the MSB.
    logic [WIDTH:0]                  clear_chain;
    // One-hot winner: din[i] set with nothing set above it.
    logic [WIDTH-1:0]                win;
    // term[b][i] = win[i] when bit b of index i is 1.
    logic [OUT_W-1:0][WIDTH-1:0]     term;
    logic [OUT_W-1:0]                idx;
    logic                            any_set;
    logic [OUT_W-1:0]                dout_next;
    logic                            valid_next;
    logic [OUT_W-1:0]                dout_reg;
    logic                            valid_reg;

    assign clear_chain[WIDTH] = 1'b1;

    // Scan from the MSB down. Once a 1 is seen the chain is a hard 0, and a
    // 0 ANDed with X stays 0, so lower bits are masked even when unknown.
    generate
        for (genvar gi = WIDTH - 1; gi >= 0; gi--) begin : g_scan
            assign clear_chain[gi] = clear_chain[gi+1] & ~bus.din[gi];
            assign win[gi]         = clear_chain[gi+1] &  bus.din[gi];
        end
    endgenerate

    // Binary-encode the one-hot winner: each index bit ORs the winners whose
    // position has that bit set.
    generate
        for (genvar gb = 0; gb < OUT_W; gb++) begin : g_bit
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_term
                localparam logic [OUT_W-1:0] POS = OUT_W'(gi);
                assign term[gb][gi] = win[gi] & POS[gb];
            end
            assign idx[gb] = |term[gb];
        end
    endgenerate

    assign any_set = |win;

    // Enable gating: a disabled cycle forces the idle result whatever din holds.
    always_comb begin
        dout_next  = '0;
        valid_next = 1'b0;
        if (bus.en) begin
            dout_next  = idx;
            valid_next = any_set;
        end
    end

    // Single output register stage; asynchronous clear on rst_n low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            dout_reg  <= dout_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.dout  = dout_reg;
    assign bus.valid = valid_reg;
endmodule

// File: tb/tb_encoder.sv
// Directed testbench for the registered priority encoder.
module tb_encoder;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    encoder_if #(.WIDTH(8)) bus ();

    encoder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Walk vector k: bit k set, bits below it X, bits above it 0.
    function automatic logic [7:0] walk_vec(input int k);
        logic [7:0] v;
        v = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (j == k)     v[j] = 1'b1;
            else if (j < k) v[j] = 1'bx;
        end
        return v;
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.en  = 1'b1;
        bus.din = 8'hFF;
        #2;
        total_cnt++;
        if (bus.dout !== 3'd0 || bus.valid !== 1'b0)
            $display("FAIL reset_no_edge: dout=%b valid=%b required dout=000 valid=0", bus.dout, bus.valid);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.dout !== 3'd0 || bus.valid !== 1'b0)
            $display("FAIL reset_held: dout=%b valid=%b required dout=000 valid=0", bus.dout, bus.valid);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.dout !== 3'd7 || bus.valid !== 1'b1)
            $display("FAIL reset_release: dout=%b valid=%b required dout=111 valid=1", bus.dout, bus.valid);
        else pass_cnt++;
        $display("reset: released, din=ff -> dout=%b valid=%b", bus.dout, bus.valid);
    endtask

    task automatic test_walk(input logic en_val);
        logic [2:0] exp_d;
        logic       exp_v;
        bus.en = en_val;
        for (int k = 0; k < 8; k++) begin
            bus.din = walk_vec(k);
            @(negedge clk);
            exp_d = en_val ? 3'(k) : 3'd0;
            exp_v = en_val;
            total_cnt++;
            if (bus.dout !== exp_d || bus.valid !== exp_v)
                $display("FAIL walk_en%0d_k%0d: dout=%b valid=%b required dout=%b valid=%b",
                         en_val, k, bus.dout, bus.valid, exp_d, exp_v);
            else pass_cnt++;
            $display("walk en=%0d din=%b -> dout=%b valid=%b", en_val, bus.din, bus.dout, bus.valid);
        end
    endtask

    task automatic test_zero_vs_bit0();
        bus.en  = 1'b1;
        bus.din = 8'h00;
        @(negedge clk);
        total_cnt++;
        if (bus.dout !== 3'd0 || bus.valid !== 1'b0)
            $display("FAIL all_zero: dout=%b valid=%b required dout=000 valid=0", bus.dout, bus.valid);
        else pass_cnt++;
        $display("zero din=00 -> dout=%b valid=%b", bus.dout, bus.valid);
        bus.din = 8'h01;
        @(negedge clk);
        total_cnt++;
        if (bus.dout !== 3'd0 || bus.valid !== 1'b1)
            $display("FAIL bit0_only: dout=%b valid=%b required dout=000 valid=1", bus.dout, bus.valid);
        else pass_cnt++;
        $display("bit0 din=01 -> dout=%b valid=%b", bus.dout, bus.valid);
    endtask

    task automatic test_patterns();
        logic [7:0] vec_din [4];
        logic       vec_en  [4];
        logic [2:0] vec_d   [4];
        logic       vec_v   [4];
        vec_din[0] = 8'b10100101; vec_en[0] = 1'b1; vec_d[0] = 3'b111; vec_v[0] = 1'b1;
        vec_din[1] = 8'b00010011; vec_en[1] = 1'b1; vec_d[1] = 3'b100; vec_v[1] = 1'b1;
        vec_din[2] = 8'b00010011; vec_en[2] = 1'b0; vec_d[2] = 3'b000; vec_v[2] = 1'b0;
        vec_din[3] = 8'b01000000; vec_en[3] = 1'b1; vec_d[3] = 3'b110; vec_v[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.en  = vec_en[i];
            bus.din = vec_din[i];
            @(negedge clk);
            total_cnt++;
            if (bus.dout !== vec_d[i] || bus.valid !== vec_v[i])
                $display("FAIL pattern_%0d: dout=%b valid=%b required dout=%b valid=%b",
                         i, bus.dout, bus.valid, vec_d[i], vec_v[i]);
            else pass_cnt++;
            $display("pattern en=%0d din=%b -> dout=%b valid=%b", vec_en[i], vec_din[i], bus.dout, bus.valid);
        end
    endtask

    task automatic test_back_to_back();
        // New din every cycle with en toggling; each result depends only on its own cycle.
        logic [7:0] b_din [5];
        logic       b_en  [5];
        logic [2:0] b_d   [5];
        logic       b_v   [5];
        b_din[0] = 8'b00001000; b_en[0] = 1'b1; b_d[0] = 3'd3; b_v[0] = 1'b1;
        b_din[1] = 8'b00100000; b_en[1] = 1'b0; b_d[1] = 3'd0; b_v[1] = 1'b0;
        b_din[2] = 8'b00000110; b_en[2] = 1'b1; b_d[2] = 3'd2; b_v[2] = 1'b1;
        b_din[3] = 8'b00000000; b_en[3] = 1'b1; b_d[3] = 3'd0; b_v[3] = 1'b0;
        b_din[4] = 8'b00100001; b_en[4] = 1'b1; b_d[4] = 3'd5; b_v[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.en  = b_en[i];
            bus.din = b_din[i];
            @(negedge clk);
            total_cnt++;
            if (bus.dout !== b_d[i] || bus.valid !== b_v[i])
                $display("FAIL b2b_%0d: dout=%b valid=%b required dout=%b valid=%b",
                         i, bus.dout, bus.valid, b_d[i], b_v[i]);
            else pass_cnt++;
            $display("b2b en=%0d din=%b -> dout=%b valid=%b", b_en[i], b_din[i], bus.dout, bus.valid);
        end
    endtask

    task automatic test_async_reset_mid();
        bus.en  = 1'b1;
        bus.din = 8'b01000000;
        @(posedge clk);
        #2;
        total_cnt++;
        if (bus.dout !== 3'd6 || bus.valid !== 1'b1)
            $display("FAIL pre_reset: dout=%b valid=%b required dout=110 valid=1", bus.dout, bus.valid);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.dout !== 3'd0 || bus.valid !== 1'b0)
            $display("FAIL async_clear: dout=%b valid=%b required dout=000 valid=0", bus.dout, bus.valid);
        else pass_cnt++;
        $display("async reset mid-cycle -> dout=%b valid=%b", bus.dout, bus.valid);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.dout !== 3'd6 || bus.valid !== 1'b1)
            $display("FAIL post_reset: dout=%b valid=%b required dout=110 valid=1", bus.dout, bus.valid);
        else pass_cnt++;
        $display("post reset din=%b -> dout=%b valid=%b", bus.din, bus.dout, bus.valid);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_walk(1'b0);
        test_walk(1'b1);
        test_zero_vs_bit0();
        test_patterns();
        test_back_to_back();
        test_async_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
